// File: rtl/uart_rx_framer_if.sv
// ---------------------------------------------------------------------------
// uart_rx_framer_if
// Push-side link between the UART receive framer and the receive buffer FIFO.
//   data_out     : byte presented to the FIFO data_in
//   write_enable : one-cycle push strobe
//   full         : FIFO full flag, returned to the framer
// Modports:
//   master : framer side (drives data_out/write_enable, reads full)
//   slave  : FIFO side   (reads data_out/write_enable, drives full)
// ---------------------------------------------------------------------------
interface uart_rx_framer_if #(
    parameter int data_width = 8
);
    logic [data_width-1:0] data_out;
    logic                  write_enable;
    logic                  full;

    modport master (
        output data_out,
        output write_enable,
        input  full
    );

    modport slave (
        input  data_out,
        input  write_enable,
        output full
    );
endinterface

// File: rtl/uart_rx_framer.sv
// ---------------------------------------------------------------------------
// uart_rx_framer
// Serial UART receiver. Synchronises the rx line, deframes
// start / data (LSB first) / optional even parity / stop, and pushes each
// good byte into the downstream FIFO with a one-cycle strobe.
// Ports:
//   clock         : system clock, rising edge
//   resetn        : synchronous active-low reset
//   rx            : asynchronous serial input, idle high
//   fifo          : master side of uart_rx_framer_if (data_out, write_enable, full)
//   framing_error : one-cycle pulse, stop bit sampled 0
//   parity_error  : one-cycle pulse, parity mismatch
//   overrun       : one-cycle pulse, good byte dropped because full was set
//   busy          : high whenever the receiver is not in IDLE
// clks_per_bit must be even and at least 4; data_width at least 2.
// ---------------------------------------------------------------------------
module uart_rx_framer #(
    parameter int data_width    = 8,
    parameter int clks_per_bit  = 16,
    parameter int parity_enable = 0
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    rx,
    uart_rx_framer_if.master        fifo,
    output logic                    framing_error,
    output logic                    parity_error,
    output logic                    overrun,
    output logic                    busy
);

    localparam int CNT_W = $clog2(clks_per_bit);
    localparam int BIT_W = $clog2(data_width + 1);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(clks_per_bit / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(clks_per_bit - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(data_width - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        PARITY    = 3'd4,
        STOP      = 3'd5
    } state_t;

    // Even parity: the parity bit equals the XOR of the data bits.
    function automatic logic parity_of(input logic [data_width-1:0] d);
        return ^d;
    endfunction

    logic                  rx_meta_r;
    logic                  rx_sync_r;
    state_t                state_r;
    logic [CNT_W-1:0]      cyc_cnt_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [data_width-1:0] shift_r;
    logic                  par_bad_r;
    logic [data_width-1:0] data_out_r;
    logic                  write_enable_r;
    logic                  framing_error_r;
    logic                  parity_error_r;
    logic                  overrun_r;
    logic                  busy_r;

    // Two-flop synchronizer for the asynchronous rx line; idles high.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receive state machine with registered data, strobe, pulse and busy outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r         <= WAIT_IDLE;
            cyc_cnt_r       <= '0;
            bit_cnt_r       <= '0;
            shift_r         <= '0;
            par_bad_r       <= 1'b0;
            data_out_r      <= '0;
            write_enable_r  <= 1'b0;
            framing_error_r <= 1'b0;
            parity_error_r  <= 1'b0;
            overrun_r       <= 1'b0;
            busy_r          <= 1'b1;
        end else begin
            // Pulses are high only in the cycle after the stop sample.
            write_enable_r  <= 1'b0;
            framing_error_r <= 1'b0;
            parity_error_r  <= 1'b0;
            overrun_r       <= 1'b0;

            case (state_r)
                // Guards against a line held low (break) through reset release.
                WAIT_IDLE: begin
                    if (rx_sync_r) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end

                IDLE: begin
                    if (!rx_sync_r) begin
                        state_r   <= START;
                        busy_r    <= 1'b1;
                        cyc_cnt_r <= '0;
                    end
                end

                // Re-check the start bit at its middle to reject glitches.
                START: begin
                    if (cyc_cnt_r == HALF_M1) begin
                        cyc_cnt_r <= '0;
                        if (rx_sync_r) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r   <= DATA;
                            bit_cnt_r <= '0;
                            par_bad_r <= 1'b0;
                        end
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (cyc_cnt_r == FULL_M1) begin
                        cyc_cnt_r <= '0;
                        shift_r   <= {rx_sync_r, shift_r[data_width-1:1]};
                        if (bit_cnt_r == BIT_LAST) begin
                            bit_cnt_r <= '0;
                            state_r   <= (parity_enable != 0) ? PARITY : STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        end
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CNT_W'(1);
                    end
                end

                PARITY: begin
                    if (cyc_cnt_r == FULL_M1) begin
                        cyc_cnt_r <= '0;
                        par_bad_r <= (parity_of(shift_r) != rx_sync_r);
                        state_r   <= STOP;
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CNT_W'(1);
                    end
                end

                // Mid-stop decision; returning to IDLE here allows zero-gap frames.
                STOP: begin
                    if (cyc_cnt_r == FULL_M1) begin
                        cyc_cnt_r <= '0;
                        if (!rx_sync_r) begin
                            framing_error_r <= 1'b1;
                            state_r         <= WAIT_IDLE;
                        end else if (par_bad_r) begin
                            parity_error_r <= 1'b1;
                            state_r        <= IDLE;
                            busy_r         <= 1'b0;
                        end else if (fifo.full) begin
                            overrun_r <= 1'b1;
                            state_r   <= IDLE;
                            busy_r    <= 1'b0;
                        end else begin
                            data_out_r     <= shift_r;
                            write_enable_r <= 1'b1;
                            state_r        <= IDLE;
                            busy_r         <= 1'b0;
                        end
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CNT_W'(1);
                    end
                end

                default: begin
                    state_r <= WAIT_IDLE;
                    busy_r  <= 1'b1;
                end
            endcase
        end
    end

    assign fifo.data_out     = data_out_r;
    assign fifo.write_enable = write_enable_r;
    assign framing_error     = framing_error_r;
    assign parity_error      = parity_error_r;
    assign overrun           = overrun_r;
    assign busy              = busy_r;

endmodule
